// File: rtl/arb_rr4.sv
// Four-way round-robin arbiter with a hold limit: an owner that keeps requesting
// is preempted after MAX_HOLD cycles if anyone else is waiting.
module arb_rr4 #(
  parameter int unsigned MAX_HOLD = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] req,
  output logic [3:0] gnt,
  output logic [1:0] gnt_id,
  output logic       busy,
  output logic       timeout
);

  // state | meaning
  // IDLE  | no owner, arbitrate on any request
  // GRANT | one owner holds the resource; gnt_id is the owner index
  typedef enum logic {IDLE, GRANT} state_t;

  localparam logic [3:0] MAX_CNT = 4'(MAX_HOLD);

  state_t     state;
  logic [1:0] ptr;
  logic [3:0] cnt;

  logic       win_found;
  logic [1:0] win_idx;
  logic [3:0] cand;
  logic [1:0] probe;

  // Owner bit is masked out so a preempted owner is skipped; on release it is
  // already zero, and in IDLE gnt is zero so all requesters compete.
  always_comb begin
    cand      = req & ~gnt;
    win_found = 1'b0;
    win_idx   = 2'd0;
    probe     = 2'd0;
    for (int i = 0; i < 4; i++) begin
      probe = ptr + 2'(i);
      if (!win_found && cand[probe]) begin
        win_found = 1'b1;
        win_idx   = probe;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= IDLE;
      gnt     <= 4'b0000;
      gnt_id  <= 2'd0;
      busy    <= 1'b0;
      timeout <= 1'b0;
      cnt     <= 4'd0;
      ptr     <= 2'd0;
    end else begin
      timeout <= 1'b0;
      if (state == IDLE) begin
        if (win_found) begin
          state  <= GRANT;
          gnt    <= 4'b0001 << win_idx;
          gnt_id <= win_idx;
          busy   <= 1'b1;
          cnt    <= 4'd1;
          ptr    <= win_idx + 2'd1;
        end
      end else if (req[gnt_id]) begin
        if (cnt < MAX_CNT) begin
          cnt <= cnt + 4'd1;
        end else if (win_found) begin
          gnt     <= 4'b0001 << win_idx;
          gnt_id  <= win_idx;
          cnt     <= 4'd1;
          ptr     <= win_idx + 2'd1;
          timeout <= 1'b1;
        end
      end else if (win_found) begin
        gnt    <= 4'b0001 << win_idx;
        gnt_id <= win_idx;
        cnt    <= 4'd1;
        ptr    <= win_idx + 2'd1;
      end else begin
        state  <= IDLE;
        gnt    <= 4'b0000;
        gnt_id <= 2'd0;
        busy   <= 1'b0;
        cnt    <= 4'd0;
      end
    end
  end

endmodule

// File: tb/tb_arb_rr4.sv
// Bench for arb_rr4 (MAX_HOLD=4): directed scenarios plus random traffic,
// checked against an integer-level round-robin model.
module tb_arb_rr4;

  localparam int HOLD = 4;

  logic       clk;
  logic       rst_n;
  logic [3:0] req;
  logic [3:0] gnt;
  logic [1:0] gnt_id;
  logic       busy;
  logic       timeout;

  int vectors = 0;
  int errors  = 0;

  // reference model: owner index (-1 = none), hold count, search start
  int m_owner = -1;
  int m_cnt   = 0;
  int m_ptr   = 0;
  bit m_to    = 0;

  arb_rr4 #(.MAX_HOLD(HOLD)) dut (
    .clk(clk), .rst_n(rst_n), .req(req),
    .gnt(gnt), .gnt_id(gnt_id), .busy(busy), .timeout(timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int pick(input logic [3:0] mask, input int start);
    for (int k = 0; k < 4; k++) begin
      if (mask[(start + k) % 4]) return (start + k) % 4;
    end
    return -1;
  endfunction

  function automatic logic [7:0] expected();
    logic [3:0] g;
    logic [1:0] id;
    g  = (m_owner >= 0) ? 4'(1 << m_owner) : 4'b0000;
    id = (m_owner >= 0) ? 2'(m_owner) : 2'd0;
    return {g, id, (m_owner >= 0), m_to};
  endfunction

  task automatic model_edge(input logic [3:0] r, input logic rb);
    int w;
    if (!rb) begin
      m_owner = -1; m_cnt = 0; m_ptr = 0; m_to = 0;
      return;
    end
    m_to = 0;
    if (m_owner < 0 || !r[m_owner]) begin
      w = pick(r, m_ptr);
      if (w >= 0) begin m_owner = w; m_cnt = 1; m_ptr = (w + 1) % 4; end
      else m_owner = -1;
    end else if (m_cnt < HOLD) begin
      m_cnt++;
    end else begin
      w = pick(r & ~(4'b0001 << m_owner), m_ptr);
      if (w >= 0) begin m_owner = w; m_cnt = 1; m_ptr = (w + 1) % 4; m_to = 1; end
    end
  endtask

  task automatic step(input logic [3:0] r, input logic rb);
    @(negedge clk);
    req   = r;
    rst_n = rb;
    @(posedge clk);
    model_edge(r, rb);
    #1;
  endtask

  task automatic test_reset();
    for (int i = 0; i < 2; i++) begin
      step(4'b1111, 1'b0);
      vectors++;
      if ({gnt, gnt_id, busy, timeout} !== 8'b0000_00_0_0) begin
        errors++;
        $display("FAIL reset cyc %0d: got %b want %b", i, {gnt, gnt_id, busy, timeout}, 8'b0);
      end
    end
  endtask

  task automatic test_single_grant();
    step(4'b0100, 1'b1);
    vectors++;
    if ({gnt, gnt_id, busy, timeout} !== 8'b0100_10_1_0) begin
      errors++;
      $display("FAIL single_grant: got %b want %b", {gnt, gnt_id, busy, timeout}, 8'b0100_10_1_0);
    end
    step(4'b0000, 1'b1);
    vectors++;
    if ({gnt, gnt_id, busy, timeout} !== 8'b0000_00_0_0) begin
      errors++;
      $display("FAIL single_release: got %b want %b", {gnt, gnt_id, busy, timeout}, 8'b0);
    end
  endtask

  task automatic test_rotation();
    logic [7:0] exp_v;
    step(4'b0000, 1'b0);
    for (int i = 0; i < 20; i++) begin
      step(4'b1111, 1'b1);
      exp_v = expected();
      vectors++;
      if ({gnt, gnt_id, busy, timeout} !== exp_v) begin
        errors++;
        $display("FAIL rotation cyc %0d: got %b want %b", i, {gnt, gnt_id, busy, timeout}, exp_v);
      end
    end
  endtask

  task automatic test_back_to_back();
    step(4'b0000, 1'b0);
    step(4'b0001, 1'b1);
    step(4'b0110, 1'b1);
    vectors++;
    if ({gnt, gnt_id, busy, timeout} !== 8'b0010_01_1_0) begin
      errors++;
      $display("FAIL back_to_back: got %b want %b", {gnt, gnt_id, busy, timeout}, 8'b0010_01_1_0);
    end
  endtask

  task automatic test_lone_holder();
    for (int i = 0; i < 20; i++) begin
      step(4'b1000, 1'b1);
      vectors++;
      if ({gnt, gnt_id, busy, timeout} !== 8'b1000_11_1_0) begin
        errors++;
        $display("FAIL lone_holder cyc %0d: got %b want %b", i, {gnt, gnt_id, busy, timeout}, 8'b1000_11_1_0);
      end
    end
  endtask

  task automatic test_reset_mid();
    step(4'b0100, 1'b1);
    vectors++;
    if ({gnt, gnt_id, busy, timeout} !== 8'b0100_10_1_0) begin
      errors++;
      $display("FAIL reset_mid_owner: got %b want %b", {gnt, gnt_id, busy, timeout}, 8'b0100_10_1_0);
    end
    step(4'b0100, 1'b0);
    vectors++;
    if ({gnt, gnt_id, busy, timeout} !== 8'b0000_00_0_0) begin
      errors++;
      $display("FAIL reset_mid_drop: got %b want %b", {gnt, gnt_id, busy, timeout}, 8'b0);
    end
    step(4'b1010, 1'b1);
    vectors++;
    if ({gnt, gnt_id, busy, timeout} !== 8'b0010_01_1_0) begin
      errors++;
      $display("FAIL reset_mid_rearb: got %b want %b", {gnt, gnt_id, busy, timeout}, 8'b0010_01_1_0);
    end
  endtask

  task automatic test_random();
    logic [7:0] exp_v;
    logic [3:0] r;
    logic       rb;
    for (int i = 0; i < 400; i++) begin
      r  = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 3) == 0) r = 4'b1111;
      rb = ($urandom_range(0, 31) != 0);
      step(r, rb);
      exp_v = expected();
      vectors++;
      if ({gnt, gnt_id, busy, timeout} !== exp_v) begin
        errors++;
        $display("FAIL random cyc %0d req %b rst_n %b: got %b want %b",
                 i, r, rb, {gnt, gnt_id, busy, timeout}, exp_v);
      end
    end
  endtask

  initial begin
    rst_n = 1'b0;
    req   = 4'b0000;
    test_reset();
    test_single_grant();
    test_rotation();
    test_back_to_back();
    test_lone_holder();
    test_reset_mid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
